// File: rtl/led_matrix_defs.sv
// Shared field positions, matrix size and scan-state encoding for the LED matrix receiver.
// No backpressure anywhere in this path: every pixel word is consumed on arrival.
package led_matrix_defs;

  localparam int MATRIX_DIM = 16;
  localparam int RED_BIT    = 9;
  localparam int GRN_BIT    = 8;
  localparam int Y_MSB      = 7;
  localparam int Y_LSB      = 4;
  localparam int X_MSB      = 3;
  localparam int X_LSB      = 0;

  typedef enum logic [1:0] {
    ST_RESET_IDLE = 2'd0,
    ST_BLANK      = 2'd1,
    ST_DRIVE      = 2'd2
  } scan_state_t;

  function automatic logic [8:0] popcount256(input logic [MATRIX_DIM*MATRIX_DIM-1:0] v);
    logic [8:0] n;
    n = '0;
    for (int i = 0; i < MATRIX_DIM*MATRIX_DIM; i++) begin
      n = n + {8'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/led_scan_timer.sv
// Row scan sequencer: one idle cycle after reset, then BLANK/DRIVE per row, rows 0..15 cyclically.
// All outputs come from registers; frame_start is high for the first BLANK cycle of row 0.
module led_scan_timer
  import led_matrix_defs::*;
#(
  parameter logic [15:0] ROW_CYCLES   = 16'd2000,
  parameter logic [15:0] BLANK_CYCLES = 16'd100
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic [3:0] o_row,
  output logic       o_drive_en,
  output logic       o_frame_start
);

  localparam logic [15:0] BLANK_LAST = BLANK_CYCLES - 16'd1;
  localparam logic [15:0] DRIVE_LAST = ROW_CYCLES - BLANK_CYCLES - 16'd1;

  scan_state_t r_state;
  logic [15:0] r_cnt;
  logic [3:0]  r_row;
  logic        r_frame_start;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_RESET_IDLE;
      r_cnt         <= '0;
      r_row         <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      case (r_state)
        ST_RESET_IDLE: begin
          r_state       <= ST_BLANK;
          r_cnt         <= '0;
          r_row         <= '0;
          r_frame_start <= 1'b1;
        end
        ST_BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            r_state <= ST_DRIVE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_DRIVE: begin
          if (r_cnt == DRIVE_LAST) begin
            r_state       <= ST_BLANK;
            r_cnt         <= '0;
            r_row         <= r_row + 4'd1;
            // Wrapping from the last row back to row 0 starts a new frame.
            r_frame_start <= (r_row == 4'(MATRIX_DIM - 1));
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: begin
          r_state <= ST_RESET_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_row         = r_row;
  assign o_drive_en    = (r_state == ST_DRIVE);
  assign o_frame_start = r_frame_start;

endmodule

// File: rtl/led_matrix_scan_rx.sv
// Collects one sender cycle of pixel words into a frame and scans it out row by row on a 16x16 bicolour matrix.
// LEDIN is registered then written 1 clk later; all matrix outputs are registered; no backpressure.
module led_matrix_scan_rx
  import led_matrix_defs::*;
#(
  parameter logic [21:0] WINDOW_CYCLES = 22'd256128,
  parameter logic [15:0] ROW_CYCLES    = 16'd2000,
  parameter logic [15:0] BLANK_CYCLES  = 16'd100
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic [9:0]            LEDIN,
  output logic [MATRIX_DIM-1:0] ROW,
  output logic [MATRIX_DIM-1:0] COLR,
  output logic [MATRIX_DIM-1:0] COLG,
  output logic                  FRAME_TICK,
  output logic [8:0]            PIX_CNT
);

  logic [9:0]  r_word;
  logic [21:0] r_win;

  logic [MATRIX_DIM-1:0][MATRIX_DIM-1:0] r_wr_red,  r_wr_grn;
  logic [MATRIX_DIM-1:0][MATRIX_DIM-1:0] r_rdy_red, r_rdy_grn;
  logic [MATRIX_DIM-1:0][MATRIX_DIM-1:0] r_dsp_red, r_dsp_grn;

  logic                               w_red;
  logic                               w_grn;
  logic [3:0]                         w_y;
  logic [3:0]                         w_x;
  logic                               w_wrap;
  logic [MATRIX_DIM*MATRIX_DIM-1:0]   w_lit;
  logic [8:0]                         w_pix;
  logic [3:0]                         w_row;
  logic                               w_drive_en;
  logic                               w_frame_start;

  assign w_red  = r_word[RED_BIT];
  assign w_grn  = r_word[GRN_BIT];
  assign w_y    = r_word[Y_MSB:Y_LSB];
  assign w_x    = r_word[X_MSB:X_LSB];
  assign w_wrap = (r_win == WINDOW_CYCLES - 22'd1);
  assign w_lit  = r_wr_red | r_wr_grn;
  assign w_pix  = popcount256(w_lit);

  led_scan_timer #(
    .ROW_CYCLES   (ROW_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .i_clk         (CLK),
    .i_rst_n       (RSTn),
    .o_row         (w_row),
    .o_drive_en    (w_drive_en),
    .o_frame_start (w_frame_start)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_word    <= '0;
      r_win     <= '0;
      r_wr_red  <= '0;
      r_wr_grn  <= '0;
      r_rdy_red <= '0;
      r_rdy_grn <= '0;
      r_dsp_red <= '0;
      r_dsp_grn <= '0;
      PIX_CNT   <= '0;
    end else begin
      r_word <= LEDIN;
      if (w_wrap) begin
        r_win     <= '0;
        r_rdy_red <= r_wr_red;
        r_rdy_grn <= r_wr_grn;
        r_wr_red  <= '0;
        r_wr_grn  <= '0;
        PIX_CNT   <= w_pix;
      end else begin
        r_win <= r_win + 22'd1;
      end
      // Placed after the wrap clear so a word landing on the wrap cycle seeds the new window.
      if (w_red) r_wr_red[w_y][w_x] <= 1'b1;
      if (w_grn) r_wr_grn[w_y][w_x] <= 1'b1;
      if (w_frame_start) begin
        r_dsp_red <= r_rdy_red;
        r_dsp_grn <= r_rdy_grn;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ROW        <= '0;
      COLR       <= '0;
      COLG       <= '0;
      FRAME_TICK <= 1'b0;
    end else begin
      ROW        <= w_drive_en ? ({{(MATRIX_DIM-1){1'b0}}, 1'b1} << w_row) : '0;
      COLR       <= w_drive_en ? r_dsp_red[w_row] : '0;
      COLG       <= w_drive_en ? r_dsp_grn[w_row] : '0;
      FRAME_TICK <= w_frame_start;
    end
  end

endmodule

// File: tb/tb_led_matrix_scan_rx.sv
// Randomized bench for led_matrix_scan_rx with a window/frame arithmetic reference model.
// Cycle c = number of rising edges since reset release; outputs are sampled on falling edges.
module tb_led_matrix_scan_rx;

  localparam int WIN   = 64;
  localparam int ROWC  = 8;
  localparam int BLK   = 2;
  localparam int FRAME = ROWC * 16;
  localparam int WMAX  = 64;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic [9:0]  LEDIN;
  logic [15:0] ROW, COLR, COLG;
  logic        FRAME_TICK;
  logic [8:0]  PIX_CNT;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit run   = 1'b0;

  // m_red[w][y] holds the red bits of the pixels accumulated in window w (window w is latched at edge w*WIN).
  logic [15:0] m_red [WMAX][16];
  logic [15:0] m_grn [WMAX][16];

  logic [15:0] e_row, e_r, e_g;
  logic        e_t;
  int          e_p;

  led_matrix_scan_rx #(
    .WINDOW_CYCLES (22'd64),
    .ROW_CYCLES    (16'd8),
    .BLANK_CYCLES  (16'd2)
  ) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .LEDIN      (LEDIN),
    .ROW        (ROW),
    .COLR       (COLR),
    .COLG       (COLG),
    .FRAME_TICK (FRAME_TICK),
    .PIX_CNT    (PIX_CNT)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (run) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d t=%0t got=%0h want=%0h", tag, cyc, $time, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int w = 0; w < WMAX; w++) begin
      for (int r = 0; r < 16; r++) begin
        m_red[w][r] = '0;
        m_grn[w][r] = '0;
      end
    end
  endtask

  function automatic int pop_window(input int w);
    int n;
    n = 0;
    for (int r = 0; r < 16; r++) n += $countones(m_red[w][r] | m_grn[w][r]);
    return n;
  endfunction

  function automatic logic [9:0] rand_word(input int dens);
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(0, 99) < dens) return v[9:0];
    return 10'd0;
  endfunction

  // Word on LEDIN during cycle c is registered at edge c+1 and written at edge c+2.
  task automatic drive(input logic [9:0] w);
    int m;
    LEDIN = w;
    m = (cyc + 2) / WIN + 1;
    if (m < WMAX) begin
      if (w[9]) m_red[m][w[7:4]][w[3:0]] = 1'b1;
      if (w[8]) m_grn[m][w[7:4]][w[3:0]] = 1'b1;
    end
  endtask

  function automatic logic [9:0] pick_a();
    case (cyc)
      70:       return 10'b10_0011_0101;
      200:      return 10'b11_0000_0000;
      201, 202: return 10'b10_0000_0000;
      318, 382: return 10'b01_1111_1111;
      default:  return (cyc >= 700) ? rand_word(60) : (cyc >= 512) ? rand_word(25) : 10'd0;
    endcase
  endfunction

  always @(negedge CLK) begin
    if (!RSTn) begin
      chk("rst_ROW",  {16'd0, ROW},  32'd0);
      chk("rst_COLR", {16'd0, COLR}, 32'd0);
      chk("rst_COLG", {16'd0, COLG}, 32'd0);
      chk("rst_TICK", {31'd0, FRAME_TICK}, 32'd0);
      chk("rst_PIX",  {23'd0, PIX_CNT}, 32'd0);
    end else if (run && cyc >= 1) begin
      e_row = '0; e_r = '0; e_g = '0; e_t = 1'b0;
      if (cyc >= 2) begin
        int p, k, w, row;
        p = (cyc - 2) % FRAME;
        k = (cyc - 2) / FRAME;
        e_t = (p == 0);
        if ((p % ROWC) >= BLK) begin
          row   = p / ROWC;
          // Displayed set = last window latched at or before the frame-start cycle 1+FRAME*k.
          w     = (1 + FRAME * k) / WIN;
          e_row = 16'd1 << row;
          if (w < WMAX) begin
            e_r = m_red[w][row];
            e_g = m_grn[w][row];
          end
        end
      end
      e_p = (cyc >= WIN && cyc / WIN < WMAX) ? pop_window(cyc / WIN) : 0;
      chk("ROW",  {16'd0, ROW},  {16'd0, e_row});
      chk("COLR", {16'd0, COLR}, {16'd0, e_r});
      chk("COLG", {16'd0, COLG}, {16'd0, e_g});
      chk("TICK", {31'd0, FRAME_TICK}, {31'd0, e_t});
      chk("PIX",  {23'd0, PIX_CNT}, e_p);
    end
  end

  initial begin
    RSTn  = 1'b0;
    LEDIN = '0;
    clear_model();
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    #2;
    cyc  = 0;
    run  = 1'b1;
    RSTn = 1'b1;

    for (int i = 0; i < 1500; i++) begin
      @(posedge CLK);
      #1;
      if (cyc >= 900 && ((cyc - 2) % FRAME) == 60) break;
      drive(pick_a());
    end

    // Scan is now driving row 7: reset asynchronously mid-row and mid-window.
    chk("pre_rst_ROW", {16'd0, ROW}, 32'h0000_0080);
    #2;
    RSTn  = 1'b0;
    run   = 1'b0;
    LEDIN = '0;
    #1;
    chk("async_ROW",  {16'd0, ROW},  32'd0);
    chk("async_COLR", {16'd0, COLR}, 32'd0);
    chk("async_COLG", {16'd0, COLG}, 32'd0);
    chk("async_TICK", {31'd0, FRAME_TICK}, 32'd0);
    chk("async_PIX",  {23'd0, PIX_CNT}, 32'd0);
    clear_model();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    #2;
    cyc  = 0;
    run  = 1'b1;
    RSTn = 1'b1;

    for (int i = 0; i < 700; i++) begin
      @(posedge CLK);
      #1;
      drive((cyc < 300) ? 10'd0 : rand_word(40));
    end

    repeat (2) @(posedge CLK);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
